// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron
//  Description : Single leaky integrate-and-fire neuron. A 1-bit spike train
//                on bit0 is integrated into an unsigned membrane potential
//                that leaks geometrically (v - v>>LEAK_SHIFT) every cycle.
//                When the next potential reaches THRESHOLD the neuron emits
//                a one-cycle spike, reloads V_RESET and ignores its input
//                for REFRACT cycles. led0 is a retriggerable stretch of the
//                spike, LED_HOLD cycles long, for driving a board LED.
//
//  Ports       : clk        in   rising-edge clock
//                rst        in   asynchronous reset, active low
//                bit0       in   input spike, synchronous to clk
//                spike      out  registered one-cycle fire pulse
//                led0       out  stretched spike indicator
//                spike_cnt  out  [15:0] saturating spike count
//                                (only with LIF_SPIKE_CNT_EN defined)
//                v_mem      out  [WIDTH-1:0] membrane potential
//
//  Options     : `define LIF_SPIKE_CNT_EN to add the spike_cnt output.
//
//  Revision    : 1.0  initial release
// ============================================================================
module lif_neuron #(
    parameter int          WIDTH      = 32,
    parameter int unsigned WEIGHT     = 10,
    parameter int          LEAK_SHIFT = 3,
    parameter int unsigned THRESHOLD  = 50,
    parameter int unsigned V_RESET    = 0,
    parameter int unsigned REFRACT    = 4,
    parameter int unsigned LED_HOLD   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit0,
    output logic             spike,
    output logic             led0,
`ifdef LIF_SPIKE_CNT_EN
    output logic [15:0]      spike_cnt,
`endif
    output logic [WIDTH-1:0] v_mem
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    // A zero-length refractory period still gets a 1-bit counter so the
    // counter logic below does not need a special case; it is simply
    // always loaded with 0.
    localparam int REFR_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int LED_W  = $clog2(LED_HOLD + 1);

    localparam logic [WIDTH:0]    C_WEIGHT    = (WIDTH + 1)'(WEIGHT);
    localparam logic [WIDTH:0]    C_THRESHOLD = (WIDTH + 1)'(THRESHOLD);
    localparam logic [WIDTH-1:0]  C_V_RESET   = WIDTH'(V_RESET);
    localparam logic [WIDTH-1:0]  C_V_MAX     = '1;
    localparam logic [REFR_W-1:0] C_REFRACT   = REFR_W'(REFRACT);
    localparam logic [REFR_W-1:0] C_REFR_ONE  = REFR_W'(1);
    localparam logic [LED_W-1:0]  C_LED_HOLD  = LED_W'(LED_HOLD);
    localparam logic [LED_W-1:0]  C_LED_ONE   = LED_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  v_q,     v_d;
    logic              spike_q, spike_d;
    logic [REFR_W-1:0] refr_q,  refr_d;
    logic [LED_W-1:0]  led_q,   led_d;

    // ------------------------------------------------------------------
    // Membrane datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_leak;
    logic [WIDTH:0]   w_leaked;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_v_next;
    logic             w_fire;
    logic             w_refractory;

    // Leak is taken off before the weight is added. Since w_leak <= v_q
    // the subtraction can never wrap, so only the addition needs the
    // extra carry bit.
    assign w_leak   = v_q >> LEAK_SHIFT;
    assign w_leaked = {1'b0, v_q - w_leak};
    assign w_sum    = w_leaked + (bit0 ? C_WEIGHT : '0);

    // Clamp to the largest representable potential on carry-out.
    assign w_v_next = w_sum[WIDTH] ? C_V_MAX : w_sum[WIDTH-1:0];

    // THRESHOLD is strictly below 2^WIDTH, so comparing the clamped value
    // gives the same answer as comparing the unclamped sum.
    assign w_fire       = ({1'b0, w_v_next} >= C_THRESHOLD);
    assign w_refractory = (refr_q != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        v_d     = v_q;
        spike_d = 1'b0;
        refr_d  = refr_q;
        // The LED counter free-runs down to zero unless a spike reloads it.
        led_d   = (led_q != '0) ? (led_q - C_LED_ONE) : led_q;

        if (w_refractory) begin
            // Input is ignored and the potential is pinned at V_RESET
            // until the refractory counter expires.
            v_d    = C_V_RESET;
            refr_d = refr_q - C_REFR_ONE;
        end else if (w_fire) begin
            v_d     = C_V_RESET;
            spike_d = 1'b1;
            refr_d  = C_REFRACT;
            // Reloading here also restarts a window that is still running.
            led_d   = C_LED_HOLD;
        end else begin
            v_d = w_v_next;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            spike_q <= 1'b0;
            refr_q  <= '0;
            led_q   <= '0;
        end else begin
            v_q     <= v_d;
            spike_q <= spike_d;
            refr_q  <= refr_d;
            led_q   <= led_d;
        end
    end

`ifdef LIF_SPIKE_CNT_EN
    // ------------------------------------------------------------------
    // Saturating spike counter; it advances on the same edge that raises
    // spike, so it always agrees with the number of pulses seen so far.
    // ------------------------------------------------------------------
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (spike_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spike_cnt = cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs: all taken straight from registers
    // ------------------------------------------------------------------
    assign v_mem = v_q;
    assign spike = spike_q;
    assign led0  = (led_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_neuron
//  Description : Directed self-checking bench for lif_neuron. u_dut uses the
//                default parameters; u_fast uses a weight above threshold and
//                no refractory period so that spikes can arrive inside the
//                LED hold window.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lif_neuron;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        b1   = 1'b0;
    logic        b2   = 1'b0;

    logic        spike1, led1, spike2, led2;
    logic [31:0] v1, v2;
`ifdef LIF_SPIKE_CNT_EN
    logic [15:0] cnt1, cnt2;
`endif

    int checks   = 0;
    int failures = 0;

    int integ_exp [6]  = '{10, 19, 27, 34, 40, 45};
    int leak_exp  [20] = '{40, 35, 31, 28, 25, 22, 20, 18, 16, 14,
                           13, 12, 11, 10,  9,  8,  7,  7,  7,  7};
    int from7_exp [6]  = '{17, 25, 32, 38, 44, 49};

    lif_neuron u_dut (
        .clk       (clk),
        .rst       (rst),
        .bit0      (b1),
        .spike     (spike1),
        .led0      (led1),
`ifdef LIF_SPIKE_CNT_EN
        .spike_cnt (cnt1),
`endif
        .v_mem     (v1)
    );

    lif_neuron #(
        .WEIGHT   (60),
        .REFRACT  (0)
    ) u_fast (
        .clk       (clk),
        .rst       (rst),
        .bit0      (b2),
        .spike     (spike2),
        .led0      (led2),
`ifdef LIF_SPIKE_CNT_EN
        .spike_cnt (cnt2),
`endif
        .v_mem     (v2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) tick();
        chk("rst_v", v1, 0);
        chk("rst_spike", {31'd0, spike1}, 0);
        chk("rst_led", {31'd0, led1}, 0);
        rst = 1'b1;

        // ---------------- first integration and spike ----------------
        b1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("integ_v", v1, integ_exp[i]);
            chk("integ_spike", {31'd0, spike1}, 0);
        end
        tick();                                     // edge 7
        chk("fire_v", v1, 0);
        chk("fire_spike", {31'd0, spike1}, 1);
        chk("fire_led", {31'd0, led1}, 1);

        // ---------------- refractory: 4 edges at 0 ----------------
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("refr_v", v1, 0);
            chk("refr_spike", {31'd0, spike1}, 0);
        end

        // ---------------- second period ----------------
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("integ2_v", v1, integ_exp[i]);
        end
        tick();                                     // edge 18
        chk("fire2_spike", {31'd0, spike1}, 1);
        chk("fire2_v", v1, 0);

        // Edges 19..28: refractory then integration; led high through 25.
        for (int e = 19; e <= 28; e++) begin
            tick();
            chk("hold_led", {31'd0, led1}, ((e - 18) < 8) ? 1 : 0);
            chk("p3_v", v1, (e >= 23) ? integ_exp[e - 23] : 0);
        end
`ifdef LIF_SPIKE_CNT_EN
        chk("cnt_two", {16'd0, cnt1}, 2);
`endif

        // ---------------- leak from 45 ----------------
        b1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("leak_v", v1, leak_exp[i]);
            chk("leak_spike", {31'd0, spike1}, 0);
        end

        // ---------------- integrate from 7, then async reset ----------------
        b1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("from7_v", v1, from7_exp[i]);
        end
        tick();
        chk("fire3_spike", {31'd0, spike1}, 1);
        chk("fire3_led", {31'd0, led1}, 1);

        #2 rst = 1'b0;                              // no clock edge nearby
        #1;
        chk("arst_v", v1, 0);
        chk("arst_spike", {31'd0, spike1}, 0);
        chk("arst_led", {31'd0, led1}, 0);
`ifdef LIF_SPIKE_CNT_EN
        chk("arst_cnt", {16'd0, cnt1}, 0);
`endif
        tick();
        chk("arst_hold_v", v1, 0);
        rst = 1'b1;

        // Refractory must have been cleared: first edge integrates at once.
        tick();
        chk("post_rst_v", v1, 10);
        repeat (32) tick();                         // edge 33, refractory
        chk("edge33_v", v1, 0);
`ifdef LIF_SPIKE_CNT_EN
        chk("cnt_three", {16'd0, cnt1}, 3);
        #2 rst = 1'b0;
        #1;
        chk("cnt_clear", {16'd0, cnt1}, 0);
        rst = 1'b1;
`endif
        b1 = 1'b0;

        // ---------------- LED stretch, single spike ----------------
        tick();
        b2 = 1'b1;
        tick();
        chk("fast_spike", {31'd0, spike2}, 1);
        chk("fast_led0", {31'd0, led2}, 1);
        b2 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("stretch_led", {31'd0, led2}, 1);
        end
        tick();
        chk("stretch_off", {31'd0, led2}, 0);

        // ---------------- LED retrigger ----------------
        b2 = 1'b1;
        tick();                                     // B
        b2 = 1'b0;
        repeat (2) tick();
        b2 = 1'b1;
        tick();                                     // B+3
        chk("retrig_spike", {31'd0, spike2}, 1);
        b2 = 1'b0;
        for (int e = 4; e <= 10; e++) begin
            tick();
            chk("retrig_led", {31'd0, led2}, 1);
        end
        tick();                                     // B+11
        chk("retrig_off", {31'd0, led2}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
